digit_serial_adder2: RTL and testbench
======================================

Name: digit_serial_adder2

Overview:
- Digit-serial adder controller that produces the operand digits consumed by the 2-bit ripple-add slice (carry-in plus two bit-pairs giving two sum bits and carry-out) and collects what the slice produces.
- Accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake.
- Feeds one 2-bit digit per cycle through an internal instance of that slice function, holding the inter-digit carry in a register.
- Shifts the sum digits into a result register and presents sum and carry-out over a second valid/ready handshake.

Parameters:
WIDTH, 8, operand/result width in bits; must be even and >= 2; digit count is WIDTH/2.

Ports:
clk  input  1  clock; all state updates on its rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands present
in_ready  output  1  block can accept operands
op_a  input  WIDTH  operand A
op_b  input  WIDTH  operand B
cin  input  1  carry-in
out_valid  output  1  result present
out_ready  input  1  consumer takes result
sum  output  WIDTH  (op_a + op_b + cin) mod 2^WIDTH
cout  output  1  carry-out of bit WIDTH-1
ovf  output  1  signed overflow flag (see Optional Feature)

Behaviour:
- Reset and clock: one clock, clk. Reset is rst_n, asynchronous and active-low. While rst_n is low:
  - state = IDLE
  - operand registers, carry register, digit counter and sum register = 0
  - out_valid = 0, cout = 0, ovf = 0, sum = 0
  - in_ready = 1 (decoded from IDLE), but in_valid is ignored until rst_n is high.
- States: IDLE, RUN, DONE.
- in_ready = (state == IDLE). out_valid = (state == DONE). Both are decoded from registered state; no combinational path from in_valid or out_ready.
- IDLE:
  - On an edge with in_valid=1: latch op_a, op_b; carry register <- cin; digit counter <- 0; go to RUN.
- RUN, each edge, digit k = counter:
  - a0,a1 = op_a[2k], op_a[2k+1]; b0,b1 likewise from op_b; c = carry register.
  - s0 = a0^b0^c; c1 = maj(a0,b0,c)
  - s1 = a1^b1^c1; c2 = maj(a1,b1,c1)
  - Sum register shifts right by 2 with {s1,s0} entering at bits [WIDTH-1:WIDTH-2]. Carry register <- c2.
  - On the last digit (k = WIDTH/2-1): cout <- c2, the macro-dependent ovf update is applied, go to DONE. Otherwise counter increments.
- Latency: accept edge E0; out_valid rises after edge E0 + WIDTH/2 (4 cycles for WIDTH=8).
- During RUN, sum shows partial contents and is only defined when out_valid=1.
- DONE:
  - sum, cout and ovf are held stable.
  - On an edge with out_ready=1, go to IDLE. No accept in that same edge; the minimum issue interval is WIDTH/2 + 2 cycles.
  - in_valid is ignored outside IDLE; operands change freely without effect.
- Reset mid-operation (any state): the in-flight computation is discarded, with no partial result output. All outputs take reset values.
- Width rules:
  - Counter width is clog2(WIDTH/2), minimum 1 bit.
  - Modulo-2^WIDTH wrap of sum; the carry beyond bit WIDTH-1 appears only on cout.

Optional Feature:
- Macro: DIGIT_SERIAL_ADDER2_OVF_EN.
- Defined: on the last digit, ovf <- c1 ^ c2, i.e. carry into the MSB XOR carry out of the MSB (two's-complement overflow). It is held in DONE and cleared to 0 on the transition to IDLE and on reset.
- Undefined: ovf is tied to constant 0 and no overflow logic is generated. The port still exists.

Test Plan:
- WIDTH=8, op_a=0x5A, op_b=0x33, cin=0 -> out_valid exactly 4 cycles after the accept edge; sum=0x8D, cout=0; ovf=1 with macro, 0 without.
- op_a=0xFF, op_b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Separately, op_a=0xFF, op_b=0x00, cin=1 -> sum=0x00, cout=1, ovf=0 (carry-in propagates through all digits).
- Backpressure: result 0x8D present, out_ready held 0 for 5 cycles while in_valid=1 with new operands -> out_valid stays 1, sum/cout/ovf unchanged, in_ready=0, new operands not taken. out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset mid-RUN: assert rst_n=0 two cycles after accepting 0x5A+0x33 -> out_valid=0, sum=0x00, cout=0, in_ready=1 immediately (async). After release, 0x12+0x34, cin=0 -> sum=0x46, cout=0.
- op_a=0x80, op_b=0x80, cin=0 -> sum=0x00, cout=1; ovf=1 with macro, 0 without.
- Back-to-back: three transactions with out_ready held 1 and in_valid held 1 -> each accept spaced WIDTH/2+2 = 6 cycles; results match the reference model (a+b+cin) for 0x01+0x01, 0x7F+0x01, 0xAA+0x55 with cin=1 (0x02/0, 0x80/0, 0x00/1).

Source files
------------

// File: rtl/digit_serial_adder2.sv
// Digit-serial adder: adds two WIDTH-bit operands two bits per cycle through a 2-bit ripple slice.
// Optional signed-overflow flag enabled by defining DIGIT_SERIAL_ADDER2_OVF_EN.
module digit_serial_adder2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int DIGITS = WIDTH / 2;
  localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   sum_reg;
  logic               cout_reg;
  logic [2:0]         digit_res;
  logic [WIDTH+1:0]   sum_cat;
  logic               last_digit;

  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // 2-bit ripple slice: returns {carry_out, s1, s0}
  function automatic logic [2:0] slice2(input logic [1:0] a, input logic [1:0] b,
                                        input logic c);
    logic s0, c1, s1, c2;
    s0 = a[0] ^ b[0] ^ c;
    c1 = maj(a[0], b[0], c);
    s1 = a[1] ^ b[1] ^ c1;
    c2 = maj(a[1], b[1], c1);
    return {c2, s1, s0};
  endfunction

  // Operands shift right as digits are consumed, so the current digit is always at [1:0]
  assign digit_res  = slice2(a_reg[1:0], b_reg[1:0], carry);
  assign sum_cat    = {digit_res[1:0], sum_reg};
  assign last_digit = (cnt == LAST);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_reg;
  assign cout      = cout_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)   state_next = RUN;
      RUN:     if (last_digit) state_next = DONE;
      DONE:    if (out_ready)  state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      sum_reg  <= '0;
      cout_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= op_a;
            b_reg <= op_b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_reg   <= a_reg >> 2;
          b_reg   <= b_reg >> 2;
          carry   <= digit_res[2];
          sum_reg <= sum_cat[WIDTH+1:2];
          if (last_digit) cout_reg <= digit_res[2];
          else            cnt      <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef DIGIT_SERIAL_ADDER2_OVF_EN
  logic c1_msb;
  logic ovf_reg;

  // Carry into the MSB of the last digit, for two's-complement overflow
  assign c1_msb = maj(a_reg[0], b_reg[0], carry);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovf_reg <= 1'b0;
    else if (state == RUN && last_digit)
      ovf_reg <= c1_msb ^ digit_res[2];
    else if (state == DONE && out_ready)
      ovf_reg <= 1'b0;
  end

  assign ovf = ovf_reg;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_digit_serial_adder2.sv
// Self-checking bench for digit_serial_adder2 (WIDTH=8) against an arithmetic reference model.
module tb_digit_serial_adder2;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  digit_serial_adder2 #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .cin(cin), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer addition; overflow when like-signed operands give an opposite-signed result
  task automatic model(input logic [7:0] a, input logic [7:0] b, input logic ci,
                       output logic [7:0] s, output logic co, output logic ov);
    int unsigned t;
    t  = int'(a) + int'(b) + int'(ci);
    s  = t[7:0];
    co = t[8];
`ifdef DIGIT_SERIAL_ADDER2_OVF_EN
    ov = (a[7] == b[7]) && (s[7] != a[7]);
`else
    ov = 1'b0;
`endif
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check({tag, "_ready_timeout"}, 32'(in_ready), 32'd1);
  endtask

  // Presents operands at a negedge with in_ready=1; returns after the accept edge's following negedge
  task automatic accept(input logic [7:0] a, input logic [7:0] b, input logic ci, input string tag);
    op_a = a; op_b = b; cin = ci; in_valid = 1'b1;
    wait_ready(tag);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_in_ready_run"}, 32'(in_ready), 32'd0);
  endtask

  task automatic wait_result(input string tag);
    int lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd4);
  endtask

  task automatic check_result(input logic [7:0] a, input logic [7:0] b, input logic ci,
                              input string tag);
    logic [7:0] es;
    logic       ec, eo;
    model(a, b, ci, es, ec, eo);
    check({tag, "_sum"}, 32'(sum), 32'(es));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
    check({tag, "_ovf"}, 32'(ovf), 32'(eo));
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
  endtask

  task automatic txn(input logic [7:0] a, input logic [7:0] b, input logic ci, input string tag);
    accept(a, b, ci, tag);
    wait_result(tag);
    check_result(a, b, ci, tag);
    release_result(tag);
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       rc;
    logic [7:0] held_sum;
    logic       held_cout, held_ovf;
    int         acc_cyc[3];
    logic [7:0] bb_a[3];
    logic [7:0] bb_b[3];
    logic       bb_c[3];

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; cin = 1'b0;
    // in_valid during reset must be ignored
    #12 in_valid = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    txn(8'h5A, 8'h33, 1'b0, "5a_33");
    txn(8'hFF, 8'h01, 1'b0, "ff_01");
    txn(8'hFF, 8'h00, 1'b1, "ff_00_cin");
    txn(8'h80, 8'h80, 1'b0, "80_80");

    // Backpressure: result held while new operands are offered
    accept(8'h5A, 8'h33, 1'b0, "bp");
    wait_result("bp");
    check_result(8'h5A, 8'h33, 1'b0, "bp");
    held_sum = sum; held_cout = cout; held_ovf = ovf;
    op_a = 8'h11; op_b = 8'h22; cin = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_sum", 32'(sum), 32'(held_sum));
      check("bp_cout", 32'(cout), 32'(held_cout));
      check("bp_ovf", 32'(ovf), 32'(held_ovf));
    end
    in_valid = 1'b0;
    release_result("bp");
    @(negedge clk);
    check("bp_no_accept", 32'(in_ready), 32'd1);

    // Asynchronous reset two cycles into RUN
    accept(8'h5A, 8'h33, 1'b0, "mid_rst");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_sum", 32'(sum), 32'd0);
    check("mid_rst_cout", 32'(cout), 32'd0);
    check("mid_rst_ovf", 32'(ovf), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    txn(8'h12, 8'h34, 1'b0, "post_rst");

    // Back-to-back with in_valid and out_ready held high
    bb_a = '{8'h01, 8'h7F, 8'hAA};
    bb_b = '{8'h01, 8'h01, 8'h55};
    bb_c = '{1'b0, 1'b0, 1'b1};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      op_a = bb_a[i]; op_b = bb_b[i]; cin = bb_c[i];
      wait_ready("b2b");
      acc_cyc[i] = cyc;
      @(posedge clk);
      @(negedge clk);
      wait_result("b2b");
      check_result(bb_a[i], bb_b[i], bb_c[i], "b2b");
    end
    in_valid  = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    check("b2b_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd6);
    check("b2b_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd6);

    // Randomised transactions
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom_range(1, 0));
      txn(ra, rb, rc, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
